// File: rtl/key_pkg.sv
// Shared constants for the key_debounce_multi push-button conditioner.
package key_pkg;

    localparam int KEY_TICK_DIV_DEF = 50000;
    localparam int KEY_STABLE_DEF   = 20;
    localparam int KEY_LONG_DEF     = 1000;
    localparam int KEY_REPEAT_DEF   = 200;

    // Raw KEY lines idle high; 0 means pressed.
    localparam logic KEY_RELEASED = 1'b1;

    // Width of a counter that must hold values 0..max_val, never narrower than 1 bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_tick_gen.sv
// Free-running divider producing a one-cycle sampling enable every TICK_DIV clocks.
module key_tick_gen
    import key_pkg::*;
#(
    parameter int TICK_DIV = KEY_TICK_DIV_DEF
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int TW = cnt_w(TICK_DIV - 1);
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel active-low key synchroniser/debouncer with press, release and long-press pulses.
// Auto-repeat of key_press after key_long is built only when KEY_DEBOUNCE_MULTI_REPEAT_EN is defined.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int TICK_DIV     = KEY_TICK_DIV_DEF,
    parameter int STABLE_TICKS = KEY_STABLE_DEF,
    parameter int LONG_TICKS   = KEY_LONG_DEF,
    parameter int REPEAT_TICKS = KEY_REPEAT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] KEY,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] key_long,
    output logic             any_press
);

    localparam int CW = cnt_w(STABLE_TICKS - 1);
    localparam int HW = cnt_w(LONG_TICKS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
    localparam int RW = cnt_w(REPEAT_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
`endif

    if (TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("key_debounce_multi: parameter out of range");
    end

    logic tick;

    key_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic          sync1, ks, st;
        logic          lvl, prs, rls, lng;
        logic          accept;
        logic [CW-1:0] cnt;
        logic [HW-1:0] hold;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
        logic [RW-1:0] rep;
`endif

        assign accept = (ks != st) && (cnt == CNT_LAST);

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync1 <= KEY_RELEASED;
                ks    <= KEY_RELEASED;
                st    <= KEY_RELEASED;
                cnt   <= '0;
                hold  <= '0;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
                rep   <= '0;
`endif
                lvl   <= 1'b0;
                prs   <= 1'b0;
                rls   <= 1'b0;
                lng   <= 1'b0;
            end else begin
                sync1 <= KEY[i];
                ks    <= sync1;
                prs   <= 1'b0;
                rls   <= 1'b0;
                lng   <= 1'b0;
                if (tick) begin
                    if (ks == st) begin
                        cnt <= '0;
                    end else if (accept) begin
                        st  <= ks;
                        cnt <= '0;
                        lvl <= (ks != KEY_RELEASED);
                        prs <= (ks != KEY_RELEASED);
                        rls <= (ks == KEY_RELEASED);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    // The release tick itself does not advance the hold, so a late release never fires key_long.
                    if (st == KEY_RELEASED || accept) begin
                        hold <= '0;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
                        rep  <= '0;
`endif
                    end else if (hold != HOLD_MAX) begin
                        hold <= hold + 1'b1;
                        lng  <= (hold == HOLD_LAST);
                    end
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
                    else if (rep == REP_LAST) begin
                        rep <= '0;
                        prs <= 1'b1;
                    end else begin
                        rep <= rep + 1'b1;
                    end
`endif
                end
            end
        end

        assign key_level[i]   = lvl;
        assign key_press[i]   = prs;
        assign key_release[i] = rls;
        assign key_long[i]    = lng;
    end

    assign any_press = |key_press;

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised multi-channel push-button conditioner; next generation of the single-rate key pre-processor.
- Per channel: synchronises active-low KEY inputs, debounces them with a per-channel stability counter, and emits a clean level plus one-cycle press and release pulses.
- Also emits a one-cycle long-press pulse per channel.
- Sits between board pushbuttons and game-control FSMs; all outputs are in the `clock` domain.
- Replaces the derived 20 ms clock with a clock-enable tick.

Parameters:
- WIDTH, 9: number of key channels.
- TICK_DIV, 50000: clock cycles per sampling tick (1 ms at 50 MHz); must be >= 2.
- STABLE_TICKS, 20: consecutive ticks a new input value must persist before it is accepted; must be >= 1.
- LONG_TICKS, 1000: ticks a key must stay debounced-pressed before key_long fires.
- REPEAT_TICKS, 200: auto-repeat interval in ticks (used only with the optional feature).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- KEY  input  WIDTH  raw pushbuttons, active-low (0 = pressed), asynchronous.
- key_level  output  WIDTH  debounced state, active-high (1 = pressed).
- key_press  output  WIDTH  one-cycle pulse per debounced press (and per repeat when enabled).
- key_release  output  WIDTH  one-cycle pulse per debounced release.
- key_long  output  WIDTH  one-cycle pulse when the hold reaches LONG_TICKS.
- any_press  output  1  OR-reduction of key_press, same cycle.

Behaviour:
- Reset (asynchronous on reset_n=0):
  - Synchroniser flops and stable registers go to all-ones (released).
  - All counters go to 0.
  - key_level, key_press, key_release, key_long and any_press go to 0.
- Reset mid-operation aborts any debounce in progress. After release, a key held during reset must be re-qualified by a full STABLE_TICKS.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly one cycle when the counter equals TICK_DIV-1.
  - It is a clock enable; no logic is clocked by a derived clock.
- Synchroniser: 2-flop synchroniser per channel, producing ks.
- Debounce (per channel, evaluated only on tick cycles; non-tick cycles hold state, so glitches between ticks are invisible):
  - ks == st: cnt <= 0.
  - ks != st and cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - ks != st and cnt == STABLE_TICKS-1: st <= ks and cnt <= 0.
  - Any sample equal to st mid-count restarts the qualification from 0.
- Outputs:
  - key_level = ~st, registered.
  - key_press is asserted in the cycle after st changes 1->0; key_release in the cycle after st changes 0->1. Each pulse lasts exactly 1 cycle.
- Latency: after the input settles past the synchroniser, the pulse follows the tick that takes the STABLE_TICKS-th consecutive differing sample by 1 cycle.
- Hold counter (per channel):
  - Increments on ticks while st == 0 and saturates at LONG_TICKS.
  - key_long pulses for 1 cycle on the tick it reaches LONG_TICKS.
  - Cleared to 0 when st returns to 1.
  - A release before LONG_TICKS produces no key_long.
- Channels are fully independent; simultaneous pulses on several channels in the same cycle are legal.
- Counter widths: $clog2(max+1) of their respective maxima; no wrap-around is permitted.

Optional Feature:
- Macro: KEY_DEBOUNCE_MULTI_REPEAT_EN.
- Defined:
  - After key_long fires, a per-channel repeat counter generates an additional key_press pulse (and any_press) every REPEAT_TICKS ticks while still pressed.
  - The first repeat comes REPEAT_TICKS ticks after key_long.
  - The repeat counter is cleared on release or reset.
- Undefined: no repeat counter is built; key_press fires exactly once per press. Ports are identical in both builds.

Decomposition:
- Shared package key_pkg:
  - Default constants KEY_TICK_DIV_DEF, KEY_STABLE_DEF, KEY_LONG_DEF, KEY_REPEAT_DEF.
  - KEY_RELEASED = 1'b1 constant (active-low idle level).
- Sub-module key_tick_gen (parameter TICK_DIV; ports clock, reset_n, tick). Instantiated once and shared by all channels.
- Per-channel logic is a generate loop, not a separate module.

Test Plan (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4):
- Reset: hold reset_n=0 with KEY=4'b0000 -> all outputs 0. Release reset with KEY=0000 -> key_press=4'b1111 for 1 cycle, 1 cycle after the 3rd tick following synchronisation.
- Bounce: toggle KEY[0] 1/0 every 5 cycles for 40 cycles, then hold 0 -> exactly one key_press[0] pulse, no key_release[0]. Release later -> exactly one key_release[0].
- Short glitch: KEY[1]=0 for 2 ticks, then 1 -> no pulses; key_level[1] stays 0.
- Long press: hold KEY[2]=0 -> key_press[2] once, then key_long[2] once 10 ticks after level rise. Release -> key_release[2], and key_long does not re-fire.
- Repeat (macro defined): continue holding KEY[2] -> key_press[2] pulses every 16 cycles after key_long. Macro undefined -> no further key_press[2].
- Simultaneous: press KEY[0] and KEY[3] in the same cycle -> key_press=4'b1001 and any_press=1 in one cycle. Assert reset_n=0 mid-debounce -> outputs 0 immediately.
